// File: rtl/apb_completer_mem.sv
// APB completer backed by a byte-strobed word memory, with programmable wait
// states, slave-error decode and a saturating protocol-violation counter.
module apb_completer_mem #(
   parameter int                         ADDRESS_WIDTH  = 32,
   parameter int                         DATA_WIDTH     = 32,
   parameter int                         MEM_WORDS_LOG2 = 8,
   parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR      = '0
) (
   input  logic                      pclk,
   input  logic                      preset_n,
   input  logic                      psel,
   input  logic                      penable,
   input  logic [ADDRESS_WIDTH-1:0]  paddr,
   input  logic                      pwrite,
   input  logic [DATA_WIDTH/8-1:0]   pstrb,
   input  logic [DATA_WIDTH-1:0]     pwdata,
   input  logic [2:0]                pprot,
   input  logic [3:0]                wait_cfg,
   input  logic                      priv_only,
   output logic                      pready,
   output logic [DATA_WIDTH-1:0]     prdata,
   output logic                      pslverr,
   output logic [7:0]                proto_err_cnt
);

   localparam int STRB_W    = DATA_WIDTH / 8;
   localparam int BYTE_LSB  = $clog2(STRB_W);
   localparam int DEPTH     = 2 ** MEM_WORDS_LOG2;
   localparam int MEM_BYTES = DEPTH * STRB_W;

   localparam logic [ADDRESS_WIDTH:0]   LIMIT_EXT =
      {1'b0, BASE_ADDR} + (ADDRESS_WIDTH+1)'(MEM_BYTES);
   localparam logic [ADDRESS_WIDTH-1:0] LSB_MASK  =
      ADDRESS_WIDTH'((1 << BYTE_LSB) - 1);

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_ACCESS_WAIT = 2'd1,
      S_ACCESS_DONE = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 wait_cnt_q, wait_cnt_d;
   logic [7:0]                 err_cnt_q, err_cnt_d;

   logic [ADDRESS_WIDTH-1:0]   addr_q;
   logic                       write_q;
   logic [STRB_W-1:0]          strb_q;
   logic [DATA_WIDTH-1:0]      wdata_q;
   logic                       prot0_q;
   logic                       priv_only_q;

   logic [DATA_WIDTH-1:0]      mem_q [DEPTH];

   logic                       load;
   logic                       violation;
   logic                       mismatch;
   logic                       commit;
   logic                       out_of_range;
   logic                       misaligned;
   logic                       priv_err;
   logic                       xfer_err;
   logic [ADDRESS_WIDTH:0]     addr_ext;
   logic [ADDRESS_WIDTH-1:0]   offset;
   logic [ADDRESS_WIDTH-1:0]   word_sel;
   logic [MEM_WORDS_LOG2-1:0]  idx;
   logic                       unused_bits;

   // Decode is done on the latched request so it is stable for the whole transfer
   assign addr_ext     = {1'b0, addr_q};
   assign out_of_range = (addr_ext < {1'b0, BASE_ADDR}) || (addr_ext >= LIMIT_EXT);
   assign misaligned   = |(addr_q & LSB_MASK);
   assign priv_err     = write_q && priv_only_q && !prot0_q;
   assign xfer_err     = out_of_range || misaligned || priv_err;

   assign offset   = addr_q - BASE_ADDR;
   assign word_sel = offset >> BYTE_LSB;
   assign idx      = word_sel[MEM_WORDS_LOG2-1:0];

   assign mismatch = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);

   assign unused_bits = ^{word_sel[ADDRESS_WIDTH-1:MEM_WORDS_LOG2], pprot[2:1]};

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= 4'd0;
         err_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      load       = 1'b0;
      violation  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (penable) begin
               violation = 1'b1;
            end else if (psel) begin
               state_d    = S_ACCESS_WAIT;
               wait_cnt_d = wait_cfg;
               load       = 1'b1;
            end
         end
         S_ACCESS_WAIT: begin
            if (!psel || mismatch) begin
               violation  = 1'b1;
               state_d    = S_IDLE;
               wait_cnt_d = 4'd0;
            end else if (penable) begin
               if (wait_cnt_q != 4'd0) begin
                  wait_cnt_d = wait_cnt_q - 4'd1;
               end else begin
                  state_d = S_ACCESS_DONE;
               end
            end
         end
         S_ACCESS_DONE: begin
            // A SETUP here chains straight into the next transfer
            if (psel && !penable) begin
               state_d    = S_ACCESS_WAIT;
               wait_cnt_d = wait_cfg;
               load       = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      err_cnt_d = err_cnt_q;
      if (violation && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_comb begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      commit  = 1'b0;
      if ((state_q == S_ACCESS_WAIT) && psel && penable && !mismatch &&
          (wait_cnt_q == 4'd0)) begin
         pready  = 1'b1;
         pslverr = xfer_err;
         commit  = write_q && !xfer_err;
         if (!write_q && !xfer_err) begin
            prdata = mem_q[idx];
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (load) begin
         addr_q      <= paddr;
         write_q     <= pwrite;
         strb_q      <= pstrb;
         wdata_q     <= pwdata;
         prot0_q     <= pprot[0];
         priv_only_q <= priv_only;
      end
   end

   always_ff @(posedge pclk) begin
      if (commit) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) begin
               mem_q[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
      end
   end

   assign proto_err_cnt = err_cnt_q;

endmodule
